// File: rtl/csr_fetch_pkg.sv
// Shared types and helpers for the CSR stream fetcher.
//   fetch_state_e   : top-level run FSM states
//   STR_*           : stream indices (val, col, len) into per-stream status vectors
//   final_lane_mask : lanes written by the last word of a stream of a given length
package csr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int STR_VAL   = 0;
  localparam int STR_COL   = 1;
  localparam int STR_LEN   = 2;
  localparam int NUM_STR   = 3;
  localparam int MAX_LANES = 64;

  // rem is (count mod lanes). A zero remainder means the last word is full.
  function automatic logic [MAX_LANES-1:0] final_lane_mask(input int unsigned rem,
                                                           input int unsigned lanes);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      mask[i] = (rem == 0) ? (i < lanes) : (i < rem);
    end
    return mask;
  endfunction

endpackage

// File: rtl/fetch_stream.sv
// One CSR stream: word address/count generator, credit check against the
// per-lane FIFOs, and LANES show-ahead FIFOs fed from a synchronous memory.
//   load          : latch base/count for a new run (top accepts start)
//   en/addr       : registered memory read request
//   rdata         : memory data, valid the cycle after en
//   rd/dout/empty : per-lane pop request, FIFO head, empty flag
//   issued_all    : every word of the run has been requested
//   drained       : FIFOs empty and no read outstanding
module fetch_stream
  import csr_fetch_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W-1:0]   count,
  output logic                en,
  output logic [ADDR_W-1:0]   addr,
  input  logic [LANES*W-1:0]  rdata,
  input  logic [LANES-1:0]    rd,
  output logic [LANES*W-1:0]  dout,
  output logic [LANES-1:0]    empty,
  output logic                issued_all,
  output logic                drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]    addr_q, addr_d, next_q, next_d;
  logic [ADDR_W:0]      words_q, words_d;
  logic                 en_q, en_d, last_q, last_d;
  logic                 rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [LANES-1:0]     last_mask_q, last_mask_d;
  logic [LANES-1:0]     empty_q, empty_d;
  logic [CW-1:0]        cnt_q [LANES];
  logic [CW-1:0]        cnt_d [LANES];
  logic [W-1:0]         data_q [LANES][DEPTH];
  logic [W-1:0]         data_d [LANES][DEPTH];
  logic [LANES-1:0]     push, pop;
  logic [CW-1:0]        wr_idx [LANES];
  logic [MAX_LANES-1:0] mask_full;
  logic                 credit_ok;

  // Request generation. A word is in flight from the edge that raises en
  // until the edge that pushes its data, i.e. en_q and rvalid_q both count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    addr_d      = addr_q;
    next_d      = next_q;
    words_d     = words_q;
    last_mask_d = last_mask_q;
    en_d        = 1'b0;
    last_d      = 1'b0;
    rvalid_d    = en_q;
    rlast_d     = last_q;
    mask_full   = final_lane_mask(32'(count) % 32'(LANES), LANES);

    credit_ok = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if ({1'b0, cnt_q[i]} + {{CW{1'b0}}, en_q} + {{CW{1'b0}}, rvalid_q}
          >= (CW+1)'(DEPTH)) begin
        credit_ok = 1'b0;
      end
    end

    if (load) begin
      next_d      = base;
      words_d     = ({1'b0, count} + (ADDR_W+1)'(LANES - 1)) / (ADDR_W+1)'(LANES);
      last_mask_d = mask_full[LANES-1:0];
    end else if ((words_q != 0) && credit_ok) begin
      en_d    = 1'b1;
      addr_d  = next_q;
      next_d  = next_q + 1'b1;
      words_d = words_q - 1'b1;
      last_d  = (words_q == 1);
    end
  end

  // Shift-register FIFOs: entry 0 is always the head, so dout is a flop.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      push[i]   = rvalid_q & (~rlast_q | last_mask_q[i]);
      pop[i]    = rd[i] & (cnt_q[i] != 0);
      data_d[i] = data_q[i];
      cnt_d[i]  = cnt_q[i];
      wr_idx[i] = cnt_q[i];
      if (pop[i]) begin
        for (int j = 0; j < DEPTH - 1; j++) begin
          data_d[i][j] = data_q[i][j+1];
        end
        cnt_d[i]  = cnt_q[i] - 1'b1;
        wr_idx[i] = cnt_q[i] - 1'b1;
      end
      if (push[i]) begin
        data_d[i][wr_idx[i][PW-1:0]] = rdata[i*W +: W];
        cnt_d[i] = cnt_d[i] + 1'b1;
      end
      empty_d[i] = (cnt_d[i] == 0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      next_q      <= '0;
      words_q     <= '0;
      en_q        <= 1'b0;
      last_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      last_mask_q <= '0;
      empty_q     <= '1;
      cnt_q       <= '{default: '0};
      // NOTE: the FIFO storage is a handful of flops whose head drives an
      // output, so it is reset to give a defined dout; a RAM would not be.
      data_q      <= '{default: '0};
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge value of the others.
      addr_q      <= addr_d;
      next_q      <= next_d;
      words_q     <= words_d;
      en_q        <= en_d;
      last_q      <= last_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      last_mask_q <= last_mask_d;
      empty_q     <= empty_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dout[i*W +: W] = data_q[i][0];
    end
  end

  assign en         = en_q;
  assign addr       = addr_q;
  assign empty      = empty_q;
  assign issued_all = (words_q == 0);
  assign drained    = (&empty_q) & ~en_q & ~rvalid_q;

endmodule

// File: rtl/csr_stream_fetcher.sv
// Streams the CSR val/col/len arrays from three synchronous read memories
// into per-lane FIFOs, one run per start.
//   start, nnz, rows, <s>_base : run request (sampled in IDLE)
//   <s>_en/_addr/_rdata        : memory read port per stream
//   <s>_read/_out/_empty       : per-lane consumer side per stream
//   busy, done                 : run status; done is a one-cycle pulse
module csr_stream_fetcher
  import csr_fetch_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int VAL_W  = 8,
  parameter int COL_W  = 8,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       nnz,
  input  logic [ADDR_W-1:0]       rows,
  input  logic [ADDR_W-1:0]       val_base,
  input  logic [ADDR_W-1:0]       col_base,
  input  logic [ADDR_W-1:0]       len_base,
  output logic                    val_en,
  output logic [ADDR_W-1:0]       val_addr,
  input  logic [LANES*VAL_W-1:0]  val_rdata,
  input  logic [LANES-1:0]        val_read,
  output logic [LANES*VAL_W-1:0]  val_out,
  output logic [LANES-1:0]        val_empty,
  output logic                    col_en,
  output logic [ADDR_W-1:0]       col_addr,
  input  logic [LANES*COL_W-1:0]  col_rdata,
  input  logic [LANES-1:0]        col_read,
  output logic [LANES*COL_W-1:0]  col_out,
  output logic [LANES-1:0]        col_empty,
  output logic                    len_en,
  output logic [ADDR_W-1:0]       len_addr,
  input  logic [LANES*LEN_W-1:0]  len_rdata,
  input  logic [LANES-1:0]        len_read,
  output logic [LANES*LEN_W-1:0]  len_out,
  output logic [LANES-1:0]        len_empty,
  output logic                    busy,
  output logic                    done
);

  fetch_state_e       state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, load;
  logic [NUM_STR-1:0] issued_all, drained;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (start) begin
               load    = 1'b1;
               state_d = FETCH;
             end
      FETCH: if (&issued_all) state_d = DRAIN;
      DRAIN: if (&drained) begin
               state_d = IDLE;
               done_d  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
    // busy trails the state by one edge on entry, but drops together with
    // done on the edge that returns to IDLE.
    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  fetch_stream #(.LANES(LANES), .W(VAL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_val (
    .clk(clk), .rst(rst), .load(load), .base(val_base), .count(nnz),
    .en(val_en), .addr(val_addr), .rdata(val_rdata), .rd(val_read),
    .dout(val_out), .empty(val_empty),
    .issued_all(issued_all[STR_VAL]), .drained(drained[STR_VAL])
  );

  fetch_stream #(.LANES(LANES), .W(COL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_col (
    .clk(clk), .rst(rst), .load(load), .base(col_base), .count(nnz),
    .en(col_en), .addr(col_addr), .rdata(col_rdata), .rd(col_read),
    .dout(col_out), .empty(col_empty),
    .issued_all(issued_all[STR_COL]), .drained(drained[STR_COL])
  );

  fetch_stream #(.LANES(LANES), .W(LEN_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_len (
    .clk(clk), .rst(rst), .load(load), .base(len_base), .count(rows),
    .en(len_en), .addr(len_addr), .rdata(len_rdata), .rd(len_read),
    .dout(len_out), .empty(len_empty),
    .issued_all(issued_all[STR_LEN]), .drained(drained[STR_LEN])
  );

endmodule

// File: tb/tb_csr_stream_fetcher.sv
// Self-checking bench for csr_stream_fetcher (LANES=4, 8-bit elements,
// DEPTH=4, ADDR_W=12). Memory word at address a holds, in lane i of
// stream s, the byte {a[3:0], s[1:0], i[1:0]}.
module tb_csr_stream_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] nnz = '0, rows = '0, val_base = '0, col_base = '0, len_base = '0;
  logic        val_en, col_en, len_en;
  logic [11:0] val_addr, col_addr, len_addr;
  logic [31:0] val_rdata = '0, col_rdata = '0, len_rdata = '0;
  logic [31:0] val_out, col_out, len_out;
  logic [3:0]  val_empty, col_empty, len_empty;
  logic        busy, done;

  logic [3:0]  rd_a   [3];
  logic        en_a   [3];
  logic [11:0] addr_a [3];
  logic [31:0] out_a  [3];
  logic [3:0]  emp_a  [3];

  assign en_a[0] = val_en;     assign en_a[1] = col_en;     assign en_a[2] = len_en;
  assign addr_a[0] = val_addr; assign addr_a[1] = col_addr; assign addr_a[2] = len_addr;
  assign out_a[0] = val_out;   assign out_a[1] = col_out;   assign out_a[2] = len_out;
  assign emp_a[0] = val_empty; assign emp_a[1] = col_empty; assign emp_a[2] = len_empty;

  csr_stream_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .nnz(nnz), .rows(rows),
    .val_base(val_base), .col_base(col_base), .len_base(len_base),
    .val_en(val_en), .val_addr(val_addr), .val_rdata(val_rdata), .val_read(rd_a[0]),
    .val_out(val_out), .val_empty(val_empty),
    .col_en(col_en), .col_addr(col_addr), .col_rdata(col_rdata), .col_read(rd_a[1]),
    .col_out(col_out), .col_empty(col_empty),
    .len_en(len_en), .len_addr(len_addr), .len_rdata(len_rdata), .len_read(rd_a[2]),
    .len_out(len_out), .len_empty(len_empty),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int s, input logic [11:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = {a[3:0], 2'(s), 2'(i)};
    return w;
  endfunction

  // Synchronous read memories.
  always @(posedge clk) begin
    if (val_en) val_rdata <= mem_word(0, val_addr);
    if (col_en) col_rdata <= mem_word(1, col_addr);
    if (len_en) len_rdata <= mem_word(2, len_addr);
  end

  typedef struct {
    logic [11:0] nnz, rows, vb, cb, lb;
    int mode;        // 0 none, 1 read when non-empty, 2 always read, 3 random
    int stall;       // cycles with no reads at the start of the run
    int poke;        // loop cycle at which start is re-pulsed (0 = never)
    int exp_vw;      // expected val/col words
    int exp_lw;      // expected len words
    int exp_done_at; // expected cycle of done after start (0 = any)
  } vec_t;

  int          total = 0, bad = 0;
  logic [7:0]  sb [3][4][$];
  logic [11:0] exp_addr [3];
  int          words_seen [3];
  int          done_cnt, done_at, n_cyc, mode;
  logic        prev_busy;
  vec_t        vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, then drive reads for the next edge.
  task automatic cyc();
    @(negedge clk);
    n_cyc++;
    if (done) begin
      done_cnt++;
      if (done_at == 0) done_at = n_cyc;
      check("busy_low_at_done", busy, 0);
      check("busy_high_before_done", prev_busy, 1);
    end
    prev_busy = busy;
    for (int s = 0; s < 3; s++) begin
      if (en_a[s]) begin
        words_seen[s]++;
        check($sformatf("addr_s%0d", s), addr_a[s], exp_addr[s]);
        exp_addr[s] = exp_addr[s] + 12'd1;
      end
      for (int i = 0; i < 4; i++) begin
        logic        go;
        logic [31:0] ex;
        case (mode)
          1:       go = !emp_a[s][i];
          2:       go = 1'b1;
          3:       go = !emp_a[s][i] && ($urandom_range(0, 1) == 1);
          default: go = 1'b0;
        endcase
        rd_a[s][i] = go;
        if (go && !emp_a[s][i]) begin
          if (sb[s][i].size() != 0) ex = 32'(sb[s][i].pop_front());
          else                      ex = 'x;
          check($sformatf("elem_s%0d_l%0d", s, i), 32'(out_a[s][i*8 +: 8]), ex);
        end
      end
    end
  endtask

  task automatic run(input vec_t v);
    logic [11:0] bases [3];
    logic [11:0] cnts [3];
    logic [31:0] w;
    bases[0] = v.vb; bases[1] = v.cb; bases[2] = v.lb;
    cnts[0] = v.nnz; cnts[1] = v.nnz; cnts[2] = v.rows;
    nnz = v.nnz; rows = v.rows; val_base = v.vb; col_base = v.cb; len_base = v.lb;
    for (int s = 0; s < 3; s++) begin
      exp_addr[s]   = bases[s];
      words_seen[s] = 0;
      for (int e = 0; e < int'(cnts[s]); e++) begin
        w = mem_word(s, bases[s] + 12'(e / 4));
        sb[s][e % 4].push_back(w[(e % 4)*8 +: 8]);
      end
    end
    done_cnt = 0; done_at = 0; n_cyc = 0;
    mode = (v.stall > 0) ? 0 : v.mode;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start_edge", busy, 0);
    check("val_en_after_start_edge", val_en, 0);
    cyc();
    check("busy_next_edge", busy, 1);
    check("val_en_first", val_en, v.nnz != 0);
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      if (v.stall > 0 && c == v.stall) begin
        check("stall_val_words", words_seen[0], 4);
        check("stall_col_words", words_seen[1], 4);
        check("stall_val_en", val_en, 0);
        check("stall_val_full", val_empty, 4'h0);
        mode = v.mode;
      end
      start = (v.poke != 0 && c == v.poke);
      if (start) begin
        nnz = 12'd100; val_base = 12'h999; col_base = 12'h999; len_base = 12'h999;
      end
      cyc();
    end
    start = 1'b0;
    check("done_seen", done_cnt, 1);
    if (v.exp_done_at != 0) check("done_cycle", done_at, v.exp_done_at);
    cyc(); cyc();
    check("done_once", done_cnt, 1);
    check("busy_idle", busy, 0);
    check("val_words", words_seen[0], v.exp_vw);
    check("col_words", words_seen[1], v.exp_vw);
    check("len_words", words_seen[2], v.exp_lw);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("empty_end_s%0d", s), emp_a[s], 4'hF);
      for (int i = 0; i < 4; i++)
        check($sformatf("sb_left_s%0d_l%0d", s, i), sb[s][i].size(), 0);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) rd_a[s] = 4'h0;
    mode = 0; prev_busy = 1'b0;
    //          nnz     rows    vb       cb       lb      md st pk vw lw done
    vecs[0] = '{12'd8,  12'd4,  12'h010, 12'h020, 12'h030, 1, 0, 0, 2, 1, 0};
    vecs[1] = '{12'd6,  12'd3,  12'h005, 12'h100, 12'h200, 1, 0, 0, 2, 1, 0};
    vecs[2] = '{12'd0,  12'd0,  12'h001, 12'h002, 12'h003, 1, 0, 0, 0, 0, 3};
    vecs[3] = '{12'd8,  12'd5,  12'hFFF, 12'hFFE, 12'h7FF, 2, 0, 0, 2, 2, 0};
    vecs[4] = '{12'd13, 12'd0,  12'h044, 12'h0A0, 12'h000, 3, 0, 0, 4, 0, 0};
    vecs[5] = '{12'd0,  12'd7,  12'h000, 12'h000, 12'h0C3, 1, 0, 0, 0, 2, 0};
    vecs[6] = '{12'd9,  12'd4,  12'h300, 12'h310, 12'h320, 1, 0, 3, 3, 1, 0};
    vecs[7] = '{12'd40, 12'd4,  12'h080, 12'h0C0, 12'h0F0, 1, 10, 0, 10, 1, 0};

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_empty_s%0d", s), emp_a[s], 4'hF);
      check($sformatf("rst_en_s%0d", s), en_a[s], 0);
      check($sformatf("rst_addr_s%0d", s), addr_a[s], 0);
      check($sformatf("rst_out_s%0d", s), out_a[s], 0);
    end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    cyc();

    for (int v = 0; v < 8; v++) run(vecs[v]);

    // Reset in the middle of a run with FIFOs partly filled.
    nnz = 12'd40; rows = 12'd8; val_base = 12'h040; col_base = 12'h050; len_base = 12'h060;
    exp_addr[0] = 12'h040; exp_addr[1] = 12'h050; exp_addr[2] = 12'h060;
    mode = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    check("midrun_val_filled", val_empty, 4'h0);
    rst = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("midrst_empty_s%0d", s), emp_a[s], 4'hF);
      check($sformatf("midrst_en_s%0d", s), en_a[s], 0);
      check($sformatf("midrst_addr_s%0d", s), addr_a[s], 0);
      check($sformatf("midrst_out_s%0d", s), out_a[s], 0);
    end
    check("midrst_busy", busy, 0);
    cyc();
    rst = 1'b1;
    cyc();
    run('{12'd8, 12'd8, 12'h040, 12'h050, 12'h060, 1, 0, 0, 2, 2, 0});

    // Reads on empty lanes while idle change nothing.
    mode = 2;
    repeat (3) cyc();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("idle_read_empty_s%0d", s), emp_a[s], 4'hF);
      check($sformatf("idle_read_en_s%0d", s), en_a[s], 0);
    end
    check("idle_read_busy", busy, 0);
    mode = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_stream_fetcher.md
# csr_stream_fetcher

Parametrised successor to the fixed 4-lane CSR fetcher: it streams the three CSR arrays (val, col, len) from three synchronous read memories into per-lane FIFOs for the multiply lanes. Lane count, element widths, FIFO depth and address width are parameters. New behaviour:
- run control: start/busy/done, with per-run base addresses and element counts;
- credit-based prefetch that never overflows a FIFO;
- partial final words.

## Interface
- LANES, 4, elements per memory word and number of consumer lanes.
- VAL_W, 8, val element width.
- COL_W, 8, col element width.
- LEN_W, 8, len element width.
- DEPTH, 4, per-lane FIFO depth; power of two, at least 2.
- ADDR_W, 12, word address and element-count width.

Ports (`<s>` is `val`, `col` or `len`; `<S>_W` is the matching element width):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- start  in  1  begin a run. Sampled only in IDLE.
- nnz  in  ADDR_W  element count for the val and col streams. Latched on start.
- rows  in  ADDR_W  element count for the len stream. Latched on start.
- `<s>`_base  in  ADDR_W  word base address. Latched on start.
- `<s>`_en  out  1  memory read enable.
- `<s>`_addr  out  ADDR_W  memory word address.
- `<s>`_rdata  in  LANES*`<S>`_W  read data, valid the cycle after `<s>`_en. Lane i occupies bits [i*W +: W].
- `<s>`_read  in  LANES  per-lane pop request.
- `<s>`_out  out  LANES*`<S>`_W  per-lane FIFO head (show-ahead).
- `<s>`_empty  out  LANES  per-lane empty flag.
- busy  out  1  high from the edge after start until the run completes.
- done  out  1  one-cycle pulse at run completion.

## Operation
- Top FSM states:
  - IDLE: on start, latch counts and bases, then go to FETCH.
  - FETCH: go to DRAIN once every stream has issued all of its words.
  - DRAIN: once all FIFOs are empty and no read is in flight, go to IDLE and pulse done.
- A stream with count C issues ceil(C/LANES) words at addresses base, base+1, … .
- On the final word, only lanes i < (C mod LANES) are pushed; if C mod LANES = 0, all lanes are pushed.
- Credit rule: a stream issues `<s>`_en only when occupancy + in-flight < DEPTH for every lane. At most one read is issued per stream per cycle.
- Each stream runs independently; the streams are not lockstepped.
- Pop: `<s>`_read[i] while `<s>`_empty[i]=0 removes the head of lane i. A read on an empty lane is ignored with no state change.
- Push and pop on the same lane in the same cycle is legal; occupancy is unchanged.
- Push and read on an empty lane in the same cycle: the read is ignored and the pushed entry is kept.
- start while busy is ignored.
- Count 0 on a stream: that stream issues nothing and is finished immediately.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - all `<s>`_en=0, `<s>`_addr=0, `<s>`_out=0;
  - all `<s>`_empty bits=1;
  - busy=0, done=0;
  - FIFOs empty, FSM in IDLE.
- Reset mid-run takes effect immediately; in-flight data is discarded.
- start sampled at edge k: busy=1 from edge k+1; first `<s>`_en is high in the cycle after edge k+1.
- Fetch latency: data read with `<s>`_en at edge t is written at edge t+1. `<s>`_empty[i] falls and `<s>`_out[i] is valid after edge t+1.
- Throughput: with continuous reads, one word per stream per cycle.
- Completion: done=1 and busy=0 from the edge at which the FSM returns to IDLE.
- Both counts 0: done pulses after edge k+2.
- done is registered; `<s>`_out and `<s>`_empty come directly from registers.

## Structure
- Package csr_fetch_pkg holds:
  - the FSM state type (IDLE, FETCH, DRAIN);
  - stream index constants (STR_VAL=0, STR_COL=1, STR_LEN=2);
  - a function computing the final-word lane mask.
- Sub-module fetch_stream (parameters LANES, W, DEPTH, ADDR_W) contains the address counter, word counter, in-flight flag, credit check and LANES FIFOs. It exposes issued_all and drained.
- The top level holds the FSM and three fetch_stream instances.

## Test plan
- Reset: hold rst=0 for 3 cycles → all `<s>`_empty=4'hF, busy=0, done=0, `<s>`_en=0.
- Full run (nnz=8, rows=4, LANES=4, all reads=4'hF continuously):
  - val and col emit 2 words per lane and len emits 1;
  - `<s>`_addr sequences are base, base+1;
  - done pulses exactly once and busy falls on the same edge.
- Backpressure (nnz=40, reads=0 for 10 cycles, then 4'hF):
  - val_en stops after 4 words and all lanes show occupancy 4;
  - after reads resume, all 10 words drain in order with no loss or duplication.
- Partial word (nnz=6, data pattern = address*16 + lane):
  - lanes 0-1 receive 2 elements and lanes 2-3 receive 1;
  - lanes 2-3 stay empty after their single element.
- Mid-run reset: assert rst=0 while the FIFOs are half full → outputs return to reset values immediately; a new start then fetches from the base again.
- Edge cases:
  - nnz=0, rows=0 → done after edge k+2 with no `<s>`_en;
  - a read on an empty lane leaves the state unchanged;
  - start pulsed while busy is ignored.
